// File: rtl/fc_classifier.sv
// Binary fully-connected classifier: accumulates NUM_VEC pooled 4-lane sign vectors
// against a 64-entry signed weight store and reports the higher-scoring class.
module fc_classifier #(
  parameter int unsigned NUM_VEC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [3:0][7:0]     pooled_pixels,
  input  logic                wt_we,
  input  logic [5:0]          wt_addr,
  input  logic [7:0]          wt_data,
  output logic                busy,
  output logic                done,
  output logic                class_id,
  output logic signed [15:0]  score0,
  output logic signed [15:0]  score1
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);

  state_t              state;
  logic [2:0]          vec_idx;
  logic signed [7:0]   weights [64];
  logic signed [15:0]  sum0;
  logic signed [15:0]  sum1;

  function automatic logic signed [15:0] sext(input logic signed [7:0] w);
    return {{8{w[7]}}, w};
  endfunction

  // Only the lane sign bit selects add/subtract, so 8'h00 behaves like +1.
  always_comb begin
    sum0 = '0;
    sum1 = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      if (pooled_pixels[l][7]) begin
        sum0 = sum0 - sext(weights[{1'b0, vec_idx, l[1:0]}]);
        sum1 = sum1 - sext(weights[{1'b1, vec_idx, l[1:0]}]);
      end else begin
        sum0 = sum0 + sext(weights[{1'b0, vec_idx, l[1:0]}]);
        sum1 = sum1 + sext(weights[{1'b1, vec_idx, l[1:0]}]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 64; i++) begin
        weights[i] <= '0;
      end
    end else if (wt_we && state == IDLE) begin
      weights[wt_addr] <= wt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec_idx  <= '0;
      score0   <= '0;
      score1   <= '0;
      class_id <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACCUM;
            busy    <= 1'b1;
            vec_idx <= '0;
            score0  <= '0;
            score1  <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            score0  <= score0 + sum0;
            score1  <= score1 + sum1;
            vec_idx <= vec_idx + 3'd1;
            if (vec_idx == LAST_IDX) begin
              state <= DECIDE;
            end
          end
        end
        DECIDE: begin
          class_id <= (score1 > score0);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
